divider: RTL and testbench

- Multi-cycle sequential divider, the inverse of the team's Booth multiplier.
- Takes operand1 (dividend) and operand2 (divisor); delivers quotient on lo and remainder on hi, HI/LO register convention.
- Sits beside the multiplier in the ALU/mult-div unit; started by a one-cycle start pulse, completion signalled by a one-cycle done pulse.
- Restoring shift-subtract on magnitudes, one quotient bit per clock, sign fix-up at the end.

---
 rtl/divider.sv | 106 ++++++++++
 tb/tb_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand magnitudes,
// sign fix-up in a final cycle. Quotient on lo, remainder on hi.
module divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic [CNT_W-1:0] cnt;
  logic             qsign, rsign;
  logic             sign1, sign2, last;
  logic [WIDTH:0]   trial, diff;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

  assign sign1 = SIGNED && operand1[WIDTH-1];
  assign sign2 = SIGNED && operand2[WIDTH-1];
  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign busy  = (state != IDLE);

  // Shifted partial remainder needs WIDTH+1 bits; a borrow out means restore.
  assign trial = {rem, dvd[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && operand2 != '0) state_nxt = CALC;
      CALC:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (operand2 == '0) begin
              hi       <= operand1;
              lo       <= '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              dvd   <= neg_if(operand1, sign1);
              dvs   <= neg_if(operand2, sign2);
              qsign <= sign1 ^ sign2;
              rsign <= sign1;
              rem   <= '0;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
        end
        FIX: begin
          lo       <= neg_if(dvd, qsign);
          hi       <= neg_if(rem, rsign);
          div_zero <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: signed and unsigned instances, directed vectors.
module tb_divider;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_s = 1'b0, start_u = 1'b0;
  logic [W-1:0] op1_s = '0, op2_s = '0, op1_u = '0, op2_u = '0;
  logic [W-1:0] hi_s, lo_s, hi_u, lo_u;
  logic         busy_s, done_s, dz_s, busy_u, done_u, dz_u;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  bit bd_bad = 1'b0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t qs[$];
  exp_t qu[$];

  divider #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .operand1(op1_s), .operand2(op2_s),
    .hi(hi_s), .lo(lo_s), .busy(busy_s), .done(done_s), .div_zero(dz_s));

  divider #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clock(clock), .reset(reset), .start(start_u), .operand1(op1_u), .operand2(op2_u),
    .hi(hi_u), .lo(lo_u), .busy(busy_u), .done(done_u), .div_zero(dz_u));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [W-1:0] h,
                       input logic [W-1:0] l, input logic z);
    check({tag, " lo"}, l, e.lo);
    check({tag, " hi"}, h, e.hi);
    check({tag, " div_zero"}, W'(z), W'(e.dz));
    check({tag, " latency"}, W'(cyc - e.acc), W'(e.lat));
  endtask

  // Monitors: pop one expected result per done pulse
  always @(posedge clock) begin
    #1;
    if (reset && done_s) begin
      done_cnt++;
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_done: unexpected done, got 1 expected 0");
      end else score("s", qs.pop_front(), hi_s, lo_s, dz_s);
    end
  end

  always @(posedge clock) begin
    #1;
    if (reset && done_u) begin
      if (qu.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_done: unexpected done, got 1 expected 0");
      end else score("u", qu.pop_front(), hi_u, lo_u, dz_u);
    end
  end

  always @(negedge clock) if ((busy_s && done_s) || (busy_u && done_u)) bd_bad = 1'b1;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit u, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = ez; e.acc = cyc + 1; e.lat = ez ? 0 : W + 1;
    if (u) begin
      start_u = 1'b1; op1_u = a; op2_u = b; qu.push_back(e);
    end else begin
      start_s = 1'b1; op1_s = a; op2_s = b; qs.push_back(e);
    end
    @(negedge clock);
    start_s = 1'b0; start_u = 1'b0;
    op1_s = 32'hDEAD_BEEF; op2_s = 32'h0000_0003;
    op1_u = 32'hDEAD_BEEF; op2_u = 32'h0000_0003;
  endtask

  task automatic wait_done(input bit u);
    for (int i = 0; i < 100; i++) begin
      if (u ? done_u : done_s) return;
      @(negedge clock);
    end
    checks++; errors++;
    $display("FAIL timeout: done got 0 expected 1");
  endtask

  initial begin
    bit busy_ok;
    int dc;
    repeat (3) @(negedge clock);
    check("rst hi", hi_s, '0);
    check("rst lo", lo_s, '0);
    check("rst busy", W'(busy_s), '0);
    check("rst done", W'(done_s), '0);
    check("rst div_zero", W'(dz_s), '0);
    reset = 1'b1;
    @(negedge clock);

    // 100 / 7 with busy window tracking
    issue(0, 100, 7, 2, 14, 0);
    busy_ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      if (!busy_s || done_s) busy_ok = 1'b0;
      @(negedge clock);
    end
    check("busy window", W'(busy_ok), W'(1));
    check("done at 33", W'(done_s), W'(1));
    check("busy at done", W'(busy_s), '0);

    // back-to-back start during the done cycle: -7 / -2
    issue(0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3, 0);
    check("b2b done drop", W'(done_s), '0);
    check("b2b busy", W'(busy_s), W'(1));
    wait_done(0); @(negedge clock);

    issue(0, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);
    wait_done(0); @(negedge clock);
    issue(0, 100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFF2, 0);
    wait_done(0); @(negedge clock);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0);
    wait_done(0); @(negedge clock);

    // divide by zero completes on the accepting edge
    issue(0, 5, 0, 5, 32'hFFFF_FFFF, 1);
    check("dz done", W'(done_s), W'(1));
    check("dz busy", W'(busy_s), '0);
    check("dz flag", W'(dz_s), W'(1));
    wait_done(0); @(negedge clock);
    check("dz busy after", W'(busy_s), '0);
    issue(0, 9, 3, 0, 3, 0);
    wait_done(0); @(negedge clock);

    // start while busy is ignored; results hold during CALC
    issue(0, 100, 7, 2, 14, 0);
    repeat (8) @(negedge clock);
    check("hold hi", hi_s, 0);
    check("hold lo", lo_s, 3);
    start_s = 1'b1; op1_s = 40; op2_s = 4;
    @(negedge clock);
    start_s = 1'b0;
    wait_done(0); @(negedge clock);

    // asynchronous reset mid-operation
    issue(0, 100, 7, 2, 14, 0);
    repeat (13) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst hi", hi_s, '0);
    check("arst lo", lo_s, '0);
    check("arst busy", W'(busy_s), '0);
    check("arst done", W'(done_s), '0);
    check("arst div_zero", W'(dz_s), '0);
    qs.delete();
    dc = done_cnt;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("no done after reset", W'(done_cnt), W'(dc));
    issue(0, 9, 3, 0, 3, 0);
    wait_done(0); @(negedge clock);

    // unsigned instance
    issue(1, 32'hFFFF_FFFF, 2, 1, 32'h7FFF_FFFF, 0);
    wait_done(1); @(negedge clock);
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    wait_done(1); @(negedge clock);
    @(negedge clock);

    check("s queue drained", W'(qs.size()), '0);
    check("u queue drained", W'(qu.size()), '0);
    check("busy and done overlap", W'(bd_bad), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
